// File: rtl/exp_adc_pkg.sv
// exp_adc_pkg: constants shared between the EXP ADC responder and the SPI ADC
// controller. It holds the mode encodings, the register-frame opcodes and the
// frame lengths, plus a saturating 8-bit increment used by the status counters.
package exp_adc_pkg;

  localparam logic [1:0]  MODE_CONVERSION = 2'b00;
  localparam logic [1:0]  MODE_REG_ACCESS = 2'b11;

  localparam logic [23:0] EXIT_REG        = 24'h801401;
  localparam logic [2:0]  ENTER_PATTERN   = 3'b101;

  localparam int          REG_FRAME_BITS  = 24;
  localparam int          CNV_BITS        = 32;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit: STAGES-deep flop chain that brings one asynchronous bit into the
// clk_i domain. RST_VAL is the value the whole chain takes during reset.
// Ports: clk_i (clock), rst_i (async active-high reset), d_i (async input),
//        q_o (synchronized output).
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  generate
    if (STAGES == 1) begin : g_one
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= RST_VAL;
        else       sync_q <= d_i;
      end
    end else begin : g_chain
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= {STAGES{RST_VAL}};
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
      end
    end
  endgenerate

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/axis_exp_adc_responder.sv
// axis_exp_adc_responder: SPI responder that emulates the multi-lane EXP ADC.
// It serves as a loopback/test target for the SPI ADC controller.
// Conversion samples come in on s_axis and are shifted out on NUM_SDI lanes
// during a CONVERSION frame. 24-bit register frames captured from spi_sdo are
// emitted on m_axis as {8'h0, frame}.
// Ports: aclk/areset (clock, async active-high reset); spi_csn/spi_sck/spi_sdo
//        (SPI from the controller); spi_sdi (data lanes to the controller);
//        s_axis_* (next sample); m_axis_* (decoded register frames);
//        status (frame_active, sample_loaded, mode, abort/underrun counters).
module axis_exp_adc_responder
  import exp_adc_pkg::*;
#(
  parameter int NUM_SDI     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               spi_csn,
  input  logic               spi_sck,
  input  logic               spi_sdo,
  output logic [NUM_SDI-1:0] spi_sdi,
  input  logic [31:0]        s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [31:0]        m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [31:0]        status
);

  localparam logic [5:0] CNV_EDGES = 6'(CNV_BITS / NUM_SDI);
  localparam logic [5:0] REG_EDGES = 6'(REG_FRAME_BITS);
  localparam int         FW        = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [FW-1:0] FILL_N = FW'(SYNC_STAGES);

  logic csn_s, sck_s, sdo_s;

  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk_i(aclk), .rst_i(areset), .d_i(spi_csn), .q_o(csn_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i(aclk), .rst_i(areset), .d_i(spi_sck), .q_o(sck_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdo (
    .clk_i(aclk), .rst_i(areset), .d_i(spi_sdo), .q_o(sdo_s));

  logic          csn_q, sck_q;
  logic [FW-1:0] fill_q, fill_d;
  logic          armed_q, armed_d;
  logic          active_q, active_d;
  logic [1:0]    mode_q, mode_d;
  logic [31:0]   hold_q, hold_d;
  logic          loaded_q, loaded_d;
  logic [31:0]   shift_q, shift_d;
  logic [23:0]   cap_q, cap_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          m_valid_q, m_valid_d;
  logic [31:0]   m_data_q, m_data_d;
  logic [7:0]    abort_q, abort_d;
  logic [7:0]    underrun_q, underrun_d;

  // The csn synchronizer resets to 1. That reset value does not count as
  // "seen high". armed_q only rises once the chain has filled from the pin
  // and the pin has been seen high. A controller that holds CSn low through
  // reset therefore cannot start a frame at reset release.
  logic fill_done;
  assign fill_done = (fill_q == FILL_N);

  logic csn_fall, csn_rise, sck_rise, sck_fall, s_hs;
  assign csn_fall = armed_q & csn_q & ~csn_s;
  assign csn_rise = active_q & ~csn_q & csn_s;
  assign sck_rise = active_q & ~sck_q & sck_s;
  assign sck_fall = active_q & sck_q & ~sck_s;
  assign s_hs     = s_axis_tvalid & ~loaded_q;

  always_comb begin
    fill_d     = fill_done ? fill_q : fill_q + 1'b1;
    armed_d    = armed_q | (fill_done & csn_s);
    active_d   = active_q;
    mode_d     = mode_q;
    hold_d     = hold_q;
    loaded_d   = loaded_q;
    shift_d    = shift_q;
    cap_d      = cap_q;
    cnt_d      = cnt_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    abort_d    = abort_q;
    underrun_d = underrun_q;

    if (s_hs) begin
      hold_d   = s_axis_tdata;
      loaded_d = 1'b1;
    end

    if (csn_fall) begin
      // Use the sample held before this cycle. A handshake in the same cycle
      // stays held for the next frame.
      shift_d  = loaded_q ? hold_q : 32'h0;
      loaded_d = s_hs;
      if (!loaded_q) underrun_d = sat_inc8(underrun_q);
      active_d = 1'b1;
      cap_d    = '0;
      cnt_d    = '0;
    end else if (sck_fall) begin
      shift_d = shift_q << NUM_SDI;
    end

    if (sck_rise) begin
      cap_d = {cap_q[22:0], sdo_s};
      cnt_d = (cnt_q == 6'h3F) ? cnt_q : cnt_q + 6'd1;
    end

    if (m_valid_q && m_axis_tready) m_valid_d = 1'b0;

    if (csn_rise) begin
      active_d = 1'b0;
      // The 24-edge check comes first so a register frame wins when both
      // frame lengths coincide.
      if (cnt_q == REG_EDGES) begin
        if (m_valid_q && !m_axis_tready) begin
          abort_d = sat_inc8(abort_q);
        end else begin
          m_valid_d = 1'b1;
          m_data_d  = {8'h0, cap_q};
          if (mode_q == MODE_CONVERSION && cap_q[23:21] == ENTER_PATTERN)
            mode_d = MODE_REG_ACCESS;
          else if (mode_q == MODE_REG_ACCESS && cap_q == EXIT_REG)
            mode_d = MODE_CONVERSION;
        end
      end else if (!(mode_q == MODE_CONVERSION && cnt_q == CNV_EDGES)) begin
        abort_d = sat_inc8(abort_q);
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      csn_q      <= 1'b1;
      sck_q      <= 1'b0;
      fill_q     <= '0;
      armed_q    <= 1'b0;
      active_q   <= 1'b0;
      mode_q     <= MODE_CONVERSION;
      hold_q     <= '0;
      loaded_q   <= 1'b0;
      shift_q    <= '0;
      cap_q      <= '0;
      cnt_q      <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      abort_q    <= '0;
      underrun_q <= '0;
    end else begin
      csn_q      <= csn_s;
      sck_q      <= sck_s;
      fill_q     <= fill_d;
      armed_q    <= armed_d;
      active_q   <= active_d;
      mode_q     <= mode_d;
      hold_q     <= hold_d;
      loaded_q   <= loaded_d;
      shift_q    <= shift_d;
      cap_q      <= cap_d;
      cnt_q      <= cnt_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      abort_q    <= abort_d;
      underrun_q <= underrun_d;
    end
  end

  assign spi_sdi       = (active_q && mode_q == MODE_CONVERSION) ?
                         shift_q[31 -: NUM_SDI] : '0;
  assign s_axis_tready = ~loaded_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign status        = {8'h0, underrun_q, abort_q, 4'h0, mode_q, loaded_q, active_q};

endmodule

// File: tb/tb_axis_exp_adc_responder.sv
// tb_axis_exp_adc_responder: directed bench for the EXP ADC responder with
// NUM_SDI=4 and SYNC_STAGES=2. An SPI controller model drives frames.
// Register-frame outputs are checked by a scoreboard queue and an independent
// m_axis monitor. Conversion data and status fields are compared directly.
module tb_axis_exp_adc_responder;

  localparam int NSDI = 4;
  localparam int HALF = 6;

  logic            aclk = 1'b0;
  logic            areset;
  logic            spi_csn, spi_sck, spi_sdo;
  logic [NSDI-1:0] spi_sdi;
  logic [31:0]     s_axis_tdata;
  logic            s_axis_tvalid, s_axis_tready;
  logic [31:0]     m_axis_tdata;
  logic            m_axis_tvalid, m_axis_tready;
  logic [31:0]     status;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  axis_exp_adc_responder #(.NUM_SDI(NSDI), .SYNC_STAGES(2)) dut (
    .aclk(aclk), .areset(areset),
    .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_sdo(spi_sdo), .spi_sdi(spi_sdi),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .status(status));

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // m_axis monitor: an accepted beat is sampled on the falling edge before
  // the rising edge that completes the handshake.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge aclk);
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL m_axis_unexpected got=%h exp=none", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e) begin
            bad++;
            $display("FAIL m_axis_data got=%h exp=%h", m_axis_tdata, e);
          end
        end
      end
    end
  end

  task automatic load_sample(input logic [31:0] d);
    bit done = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge aclk);
      if (s_axis_tready) done = 1;
      @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL s_axis_handshake got=timeout exp=accepted");
    end
  endtask

  // The controller model samples spi_sdi just before each SCK rising edge,
  // MSB lane first.
  task automatic spi_frame(input int nclk, input logic [23:0] word, output logic [31:0] rx);
    rx = '0;
    spi_csn = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nclk; i++) begin
      spi_sdo = (i < 24) ? word[23-i] : 1'b0;
      wait_clk(HALF);
      rx = {rx[31-NSDI:0], spi_sdi};
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
    end
    wait_clk(HALF);
    spi_csn = 1'b1;
    spi_sdo = 1'b0;
    wait_clk(10);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sdi"},    32'(spi_sdi), 32'h0);
    chk({tag, "_tready"}, 32'(s_axis_tready), 32'h1);
    chk({tag, "_mvalid"}, 32'(m_axis_tvalid), 32'h0);
    chk({tag, "_mdata"},  m_axis_tdata, 32'h0);
    chk({tag, "_status"}, status, 32'h0);
  endtask

  initial begin
    logic [31:0] rx;
    areset = 1'b1;
    spi_csn = 1'b1; spi_sck = 1'b0; spi_sdo = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    wait_clk(4);
    chk_reset_outputs("rst");
    areset = 1'b0;
    wait_clk(6);
    chk("post_rst_status", status, 32'h0);

    // Conversion frame with a loaded sample
    load_sample(32'hA5C3_0F96);
    chk("loaded_flag", 32'(status[1]), 32'h1);
    chk("tready_loaded", 32'(s_axis_tready), 32'h0);
    spi_frame(8, 24'h0, rx);
    chk("cnv_rx", rx, 32'hA5C3_0F96);
    chk("cnv_underrun", 32'(status[23:16]), 32'h0);
    chk("cnv_abort", 32'(status[15:8]), 32'h0);
    chk("cnv_loaded_clr", 32'(status[1]), 32'h0);
    chk("sdi_idle", 32'(spi_sdi), 32'h0);

    // Conversion frame with no sample loaded
    spi_frame(8, 24'h0, rx);
    chk("under_rx", rx, 32'h0);
    chk("under_cnt", 32'(status[23:16]), 32'h1);

    // Enter REG_ACCESS, then exit. Each CSn fall with no sample is an underrun.
    exp_q.push_back(32'h00A0_0000);
    spi_frame(24, 24'hA00000, rx);
    chk("enter_mode", 32'(status[3:2]), 32'h3);
    load_sample(32'hFFFF_FFFF);
    exp_q.push_back(32'h0080_1401);
    spi_frame(24, 24'h801401, rx);
    chk("reg_sdi_zero", rx, 32'h0);
    chk("exit_mode", 32'(status[3:2]), 32'h0);
    chk("exit_underrun", 32'(status[23:16]), 32'h2);

    // Short frame: aborted, mode unchanged, no m_axis beat
    spi_frame(5, 24'h0, rx);
    chk("short_abort", 32'(status[15:8]), 32'h1);
    chk("short_mode", 32'(status[3:2]), 32'h0);
    chk("short_mvalid", 32'(m_axis_tvalid), 32'h0);

    // Back-pressure: the first frame is held, the second is dropped
    m_axis_tready = 1'b0;
    exp_q.push_back(32'h0012_3456);
    spi_frame(24, 24'h123456, rx);
    spi_frame(24, 24'h654321, rx);
    chk("bp_mvalid", 32'(m_axis_tvalid), 32'h1);
    chk("bp_mdata", m_axis_tdata, 32'h0012_3456);
    chk("bp_abort", 32'(status[15:8]), 32'h2);
    chk("bp_mode", 32'(status[3:2]), 32'h0);
    m_axis_tready = 1'b1;
    wait_clk(4);
    chk("bp_drained", 32'(m_axis_tvalid), 32'h0);

    // Reset mid-frame while in REG_ACCESS with a sample loaded
    exp_q.push_back(32'h00A0_0001);
    spi_frame(24, 24'hA00001, rx);
    chk("mid_mode_reg", 32'(status[3:2]), 32'h3);
    spi_csn = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 3; i++) begin
      spi_sdo = 1'b1;
      wait_clk(HALF); spi_sck = 1'b1;
      wait_clk(HALF); spi_sck = 1'b0;
    end
    load_sample(32'hDEAD_BEEF);
    chk("mid_active", 32'(status[0]), 32'h1);
    areset = 1'b1;
    wait_clk(2);
    chk_reset_outputs("mid_rst");
    spi_csn = 1'b1; spi_sdo = 1'b0;
    wait_clk(2);
    areset = 1'b0;
    wait_clk(6);
    chk("mid_post_status", status, 32'h0);

    load_sample(32'h1234_5678);
    spi_frame(8, 24'h0, rx);
    chk("after_rst_rx", rx, 32'h1234_5678);
    chk("after_rst_underrun", 32'(status[23:16]), 32'h0);
    exp_q.push_back(32'h000A_BCDE);
    spi_frame(24, 24'h0ABCDE, rx);
    chk("after_rst_mode", 32'(status[3:2]), 32'h0);
    chk("after_rst_underrun2", 32'(status[23:16]), 32'h1);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) wait_clk(1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
